// File: rtl/shift_seq_ctrl_if.sv
// Request, result and shift-register strobe bundle of the shift sequencer.
// slave is the controller side; master is the requester/datapath side.
interface shift_seq_ctrl_if #(
  parameter int W  = 4,
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_count;
  logic          sr_load;
  logic          sr_shift_en;
  logic [W-1:0]  sr_d;
  logic [W-1:0]  sr_q;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          done;

  modport slave (
    input  in_valid, in_data, in_count, sr_q, out_ready,
    output in_ready, sr_load, sr_shift_en, sr_d, out_valid, out_data, busy, done
  );

  modport master (
    output in_valid, in_data, in_count, sr_q, out_ready,
    input  in_ready, sr_load, sr_shift_en, sr_d, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer: load a word into a right shift register, issue paced shift
// pulses, capture the result and hand it back over valid/ready.
module shift_seq_ctrl #(
  parameter int W    = 4,
  parameter int CW   = 3,
  parameter int PACE = 1
) (
  input logic           clk,
  input logic           rst,
  shift_seq_ctrl_if.slave bus
);
  localparam int RW  = $clog2(W + 1);
  localparam int PCW = $clog2(PACE + 1);
  // GAP counts down from PACE-2 to 0, giving PACE-1 quiet cycles
  localparam logic [PCW-1:0] GAP_INIT = PCW'((PACE > 1) ? PACE - 2 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, CAPTURE, OUTPUT} state_t;

  state_t         state;
  logic [RW-1:0]  rem;
  logic [RW-1:0]  count_clamped;
  logic [PCW-1:0] pace_cnt;
  logic           ready_r, load_r, shift_r, valid_r, busy_r;
  logic [W-1:0]   d_r, q_r;

  always_comb
    count_clamped = (int'(bus.in_count) > W) ? RW'(W) : RW'(bus.in_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      pace_cnt <= '0;
      ready_r  <= 1'b1;
      load_r   <= 1'b0;
      shift_r  <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      d_r      <= '0;
      q_r      <= '0;
    end else begin
      load_r  <= 1'b0;
      shift_r <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          d_r     <= bus.in_data;
          rem     <= count_clamped;
          ready_r <= 1'b0;
          busy_r  <= 1'b1;
          load_r  <= 1'b1;
          state   <= LOAD;
        end
        LOAD: if (rem != '0) begin
          shift_r <= 1'b1;
          state   <= SHIFT;
        end else begin
          state   <= CAPTURE;
        end
        SHIFT: begin
          rem <= rem - RW'(1);
          if (rem == RW'(1)) begin
            state <= CAPTURE;
          end else if (PACE > 1) begin
            pace_cnt <= GAP_INIT;
            state    <= GAP;
          end else begin
            shift_r <= 1'b1;
          end
        end
        GAP: if (pace_cnt == '0) begin
          shift_r <= 1'b1;
          state   <= SHIFT;
        end else begin
          pace_cnt <= pace_cnt - PCW'(1);
        end
        CAPTURE: begin
          q_r     <= bus.sr_q;
          valid_r <= 1'b1;
          state   <= OUTPUT;
        end
        OUTPUT: if (bus.out_ready) begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is masked by rst so a request can never land during reset
  assign bus.in_ready    = ready_r & ~rst;
  assign bus.sr_load     = load_r;
  assign bus.sr_shift_en = shift_r;
  assign bus.sr_d        = d_r;
  assign bus.out_valid   = valid_r;
  assign bus.out_data    = q_r;
  assign bus.busy        = busy_r;
  assign bus.done        = (state == OUTPUT) & bus.out_ready;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench: PACE=1 and PACE=3 controllers, each driving a zero-fill
// right shift register model.
module tb_shift_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   n_chk = 0;

  shift_seq_ctrl_if #(.W(4), .CW(3)) b1();
  shift_seq_ctrl_if #(.W(4), .CW(3)) b3();

  shift_seq_ctrl #(.W(4), .CW(3), .PACE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  shift_seq_ctrl #(.W(4), .CW(3), .PACE(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  logic [3:0] sr1 = 4'h0;
  logic [3:0] sr3 = 4'h0;
  assign b1.sr_q = sr1;
  assign b3.sr_q = sr3;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (b1.sr_load) sr1 <= b1.sr_d;
    else if (b1.sr_shift_en) sr1 <= sr1 >> 1;
    if (b3.sr_load) sr3 <= b3.sr_d;
    else if (b3.sr_shift_en) sr3 <= sr3 >> 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the PACE=1 controller. hold = cycles out_ready stays
  // low once out_valid rises; keep = leave in_valid high with data d2.
  task automatic txn1(input logic [3:0] d, input logic [2:0] c, input int hold,
                      input bit keep, input logic [3:0] d2,
                      output int lat, output int nld, output int nsh,
                      output logic [3:0] od, output int ndone, output int bad);
    lat = -1; nld = 0; nsh = 0; od = 4'h0; ndone = 0; bad = 0;
    b1.in_data   = d;
    b1.in_count  = c;
    b1.in_valid  = 1'b1;
    b1.out_ready = (hold == 0);
    chk("accept_ready", 32'(b1.in_ready), 1);
    step();
    if (keep) b1.in_data = d2;
    else b1.in_valid = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (b1.out_valid) begin
        if (lat < 0) begin
          lat = cyc;
          od  = b1.out_data;
        end else if (b1.out_data !== od) bad++;
        b1.out_ready = ((cyc - lat) >= hold);
      end
      #1;
      if (b1.sr_load) nld++;
      if (b1.sr_shift_en) nsh++;
      if (b1.sr_load && b1.sr_shift_en) bad++;
      if (b1.in_ready) bad++;
      if (b1.done) ndone++;
      if (b1.out_valid && b1.out_ready) begin
        step();
        return;
      end
      step();
    end
  endtask

  initial begin
    int lat, nld, nsh, nd, bad, lat3;
    logic [3:0] od, od3;
    int p3[$];
    int nv, ns;

    b1.in_valid = 0; b1.in_data = 0; b1.in_count = 0; b1.out_ready = 0;
    b3.in_valid = 0; b3.in_data = 0; b3.in_count = 0; b3.out_ready = 0;

    step();
    step();
    chk("rst_in_ready_low", 32'(b1.in_ready), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(b1.in_ready), 1);
    chk("idle_busy", 32'(b1.busy), 0);
    chk("idle_load", 32'(b1.sr_load), 0);
    chk("idle_shift", 32'(b1.sr_shift_en), 0);
    chk("idle_out_valid", 32'(b1.out_valid), 0);
    chk("idle_out_data", 32'(b1.out_data), 0);
    chk("idle_sr_d", 32'(b1.sr_d), 0);
    chk("idle_done", 32'(b1.done), 0);
    step();

    // basic: 0110 >> 1
    txn1(4'b0110, 3'd1, 0, 1'b0, 4'h0, lat, nld, nsh, od, nd, bad);
    chk("basic_lat", lat, 4);
    chk("basic_loads", nld, 1);
    chk("basic_shifts", nsh, 1);
    chk("basic_data", 32'(od), 32'b0011);
    chk("basic_done", nd, 1);
    chk("basic_bad", bad, 0);
    chk("basic_back_idle", 32'(b1.in_ready), 1);

    // zero count with 5 cycles of backpressure
    txn1(4'b1010, 3'd0, 5, 1'b0, 4'h0, lat, nld, nsh, od, nd, bad);
    chk("zero_lat", lat, 3);
    chk("zero_shifts", nsh, 0);
    chk("zero_data", 32'(od), 32'b1010);
    chk("zero_done", nd, 1);
    chk("zero_bad", bad, 0);
    chk("zero_back_idle", 32'(b1.in_ready), 1);
    chk("zero_valid_drop", 32'(b1.out_valid), 0);

    // count 3, then count 5 clamped to 4
    txn1(4'b1011, 3'd3, 0, 1'b0, 4'h0, lat, nld, nsh, od, nd, bad);
    chk("c3_lat", lat, 6);
    chk("c3_shifts", nsh, 3);
    chk("c3_data", 32'(od), 32'b0001);
    txn1(4'b1111, 3'd5, 0, 1'b0, 4'h0, lat, nld, nsh, od, nd, bad);
    chk("clamp1_lat", lat, 7);
    chk("clamp1_shifts", nsh, 4);
    chk("clamp1_data", 32'(od), 0);

    // busy ignore: second word held on in_valid throughout
    txn1(4'b1100, 3'd2, 0, 1'b1, 4'b0001, lat, nld, nsh, od, nd, bad);
    chk("busy_lat", lat, 5);
    chk("busy_data", 32'(od), 32'b0011);
    chk("busy_no_ready", bad, 0);
    chk("busy_idle_ready", 32'(b1.in_ready), 1);
    step();
    chk("busy2_load", 32'(b1.sr_load), 1);
    chk("busy2_sr_d", 32'(b1.sr_d), 32'b0001);
    b1.in_valid = 1'b0;
    for (int i = 0; i < 20 && !b1.out_valid; i++) step();
    chk("busy2_valid", 32'(b1.out_valid), 1);
    chk("busy2_data", 32'(b1.out_data), 0);
    step();
    chk("busy2_idle", 32'(b1.in_ready), 1);

    // pacing and clamp on the PACE=3 controller
    b3.in_data = 4'b1111; b3.in_count = 3'd7; b3.in_valid = 1'b1; b3.out_ready = 1'b1;
    step();
    b3.in_valid = 1'b0;
    lat3 = -1; od3 = 4'hF;
    for (int cyc = 1; cyc < 60; cyc++) begin
      if (b3.sr_shift_en) p3.push_back(cyc);
      if (b3.out_valid) begin
        lat3 = cyc;
        od3  = b3.out_data;
        step();
        break;
      end
      step();
    end
    chk("pace_pulses", p3.size(), 4);
    if (p3.size() > 0) chk("pace_first", p3[0], 2);
    for (int i = 1; i < p3.size(); i++) chk("pace_spacing", p3[i] - p3[i-1], 3);
    chk("pace_lat", lat3, 13);
    chk("pace_data", 32'(od3), 0);
    chk("pace_idle", 32'(b3.in_ready), 1);

    // reset during the second SHIFT of a count-3 request
    b1.in_data = 4'b1111; b1.in_count = 3'd3; b1.in_valid = 1'b1; b1.out_ready = 1'b1;
    step();
    b1.in_valid = 1'b0;
    step();
    step();
    chk("mid_shift_on", 32'(b1.sr_shift_en), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_shift", 32'(b1.sr_shift_en), 0);
    chk("mid_rst_busy", 32'(b1.busy), 0);
    chk("mid_rst_ready", 32'(b1.in_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(b1.in_ready), 1);
    nv = 0; ns = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (b1.out_valid) nv++;
      if (b1.sr_shift_en || b1.sr_load) ns++;
    end
    chk("mid_no_valid", nv, 0);
    chk("mid_no_strobe", ns, 0);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
